// File: rtl/tx_ila_gen_if.sv
// Purpose : control, config and octet-stream signals of the ILA generator.
// Latency : n/a (signal bundle only).
// Backpressure: none; the octet stream has no ready, the consumer must always accept.
//
// Signals
//   i_start  one-cycle request to begin an ILA sequence
//   i_abort  terminate the running sequence immediately
//   i_cfg    14 link-configuration octets, octet n at [8n+7:8n]
//   o_data   ILA octet (HGFEDCBA)
//   o_vld    o_data/o_k valid
//   o_k      o_data is a control character
//   o_busy   sequence in progress
//   o_done   one-cycle pulse after the last octet of a complete sequence
// master = controller / stream consumer side, slave = generator side.
interface tx_ila_gen_if;
  logic         i_start;
  logic         i_abort;
  logic [111:0] i_cfg;
  logic [7:0]   o_data;
  logic         o_vld;
  logic         o_k;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_start, i_abort, i_cfg,
    input  o_data, o_vld, o_k, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_cfg,
    output o_data, o_vld, o_k, o_busy, o_done
  );
endinterface

// File: rtl/tx_ila_gen.sv
// Purpose : JESD204B Initial Lane Alignment octet generator for one lane (MF_NUM multiframes).
// Latency : i_start sampled at a clock edge -> /R/ presented right after that edge; 4L octets back-to-back.
// Backpressure: none; octets are emitted every cycle while busy, downstream must accept them.
//
// Ports
//   clk    character clock
//   rst_n  asynchronous active-low reset
//   ila    tx_ila_gen_if.slave: start/abort/cfg in, data/vld/k/busy/done out (all outputs registered)
module tx_ila_gen #(
  parameter int F      = 2,
  parameter int K      = 16,
  parameter int MF_NUM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tx_ila_gen_if.slave   ila
);

  localparam int L  = F * K;
  localparam int IW = $clog2(L);
  localparam int MW = (MF_NUM > 1) ? $clog2(MF_NUM) : 1;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_n;
  logic [IW-1:0]  oct_q, oct_n;
  logic [MW-1:0]  mf_q, mf_n;
  logic [111:0]   cfg_q;
  logic           cap_cfg;

  logic [7:0]     data_q, data_n;
  logic           vld_q, vld_n;
  logic           k_q, k_n;
  logic           done_q, done_n;

  logic           oct_last, mf_last;
  logic [3:0]     cfg_idx;

  // Counters index the octet currently on the output, so RUN is exactly the
  // presentation window and the last octet is recognised while it is shown.
  assign oct_last = (oct_q == IW'(L - 1));
  assign mf_last  = (mf_q == MW'(MF_NUM - 1));

  // Next-state / counter process.
  always_comb begin
    state_n = state_q;
    oct_n   = oct_q;
    mf_n    = mf_q;
    done_n  = 1'b0;
    cap_cfg = 1'b0;
    case (state_q)
      IDLE: begin
        // Counters are already zero here, so entering RUN presents octet (0,0).
        if (ila.i_start && !ila.i_abort) begin
          state_n = RUN;
          cap_cfg = 1'b1;
        end
      end
      RUN: begin
        if (ila.i_abort) begin
          state_n = IDLE;
          oct_n   = '0;
          mf_n    = '0;
        end else if (oct_last && mf_last) begin
          state_n = IDLE;
          oct_n   = '0;
          mf_n    = '0;
          done_n  = 1'b1;
        end else if (oct_last) begin
          oct_n = '0;
          mf_n  = mf_q + MW'(1);
        end else begin
          oct_n = oct_q + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Octet encoder for the next presented position. cfg_q is only read in
  // multiframe 1, long after the capture cycle, so it is always settled.
  always_comb begin
    data_n  = 8'h00;
    k_n     = 1'b0;
    vld_n   = (state_n == RUN);
    cfg_idx = 4'(oct_n - IW'(2));
    if (vld_n) begin
      if (oct_n == '0) begin
        data_n = K28_0;
        k_n    = 1'b1;
      end else if (oct_n == IW'(L - 1)) begin
        data_n = K28_3;
        k_n    = 1'b1;
      end else if (mf_n == MW'(1) && oct_n == IW'(1)) begin
        data_n = K28_4;
        k_n    = 1'b1;
      end else if (mf_n == MW'(1) && oct_n >= IW'(2) && oct_n <= IW'(15)) begin
        data_n = cfg_q[{cfg_idx, 3'b000} +: 8];
      end else begin
        data_n = 8'(oct_n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oct_q   <= '0;
      mf_q    <= '0;
      cfg_q   <= '0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      oct_q   <= oct_n;
      mf_q    <= mf_n;
      if (cap_cfg) begin
        cfg_q <= ila.i_cfg;
      end
      data_q  <= data_n;
      vld_q   <= vld_n;
      k_q     <= k_n;
      done_q  <= done_n;
    end
  end

  assign ila.o_data = data_q;
  assign ila.o_vld  = vld_q;
  assign ila.o_k    = k_q;
  assign ila.o_busy = vld_q;   // busy and valid cover the same cycles
  assign ila.o_done = done_q;

endmodule

// File: tb/tb_tx_ila_gen.sv
// Purpose : self-checking bench for tx_ila_gen (F=2, K=16, MF_NUM=4 -> 128 octets).
// Latency : expected octets queued when i_start is driven, compared as the DUT presents them.
// Backpressure: none modelled; the DUT streams unconditionally.
module tb_tx_ila_gen;

  localparam int F  = 2;
  localparam int K  = 16;
  localparam int MF = 4;
  localparam int L  = F * K;

  logic clk;
  logic rst_n;

  tx_ila_gen_if ila ();

  tx_ila_gen #(.F(F), .K(K), .MF_NUM(MF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ila   (ila)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {last_of_sequence, k, data}
  logic [9:0] sb[$];
  logic       exp_done = 1'b0;
  logic       exp_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference octet map, written straight from the ILA layout.
  task automatic push_seq(input logic [111:0] cfg);
    logic [7:0] d;
    logic       k;
    logic       last;
    for (int m = 0; m < MF; m++) begin
      for (int i = 0; i < L; i++) begin
        k = 1'b0;
        if (i == 0) begin
          d = 8'h1C; k = 1'b1;
        end else if (i == L - 1) begin
          d = 8'h7C; k = 1'b1;
        end else if (m == 1 && i == 1) begin
          d = 8'h9C; k = 1'b1;
        end else if (m == 1 && i >= 2 && i <= 15) begin
          d = cfg[8*(i-2) +: 8];
        end else begin
          d = 8'(i);
        end
        last = (m == MF - 1) && (i == L - 1);
        sb.push_back({last, k, d});
      end
    end
  endtask

  // One clock: sample DUT just after the edge and compare against the model.
  task automatic cycle();
    logic [9:0] e;
    logic       exp_vld;
    @(posedge clk);
    #1;
    exp_vld = (sb.size() != 0);
    check("vld",  32'(ila.o_vld),  32'(exp_vld));
    check("busy", 32'(ila.o_busy), 32'(exp_vld));
    check("done", 32'(ila.o_done), 32'(exp_done));
    exp_done = 1'b0;
    exp_busy = exp_vld;
    if (exp_vld) begin
      e = sb.pop_front();
      check("data", 32'(ila.o_data), 32'(e[7:0]));
      check("k",    32'(ila.o_k),    32'(e[8]));
      exp_done = e[9];
    end else begin
      check("data_idle", 32'(ila.o_data), 32'h0);
      check("k_idle",    32'(ila.o_k),    32'h0);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Drives a one-cycle start; the model only accepts it when not busy.
  task automatic pulse_start();
    ila.i_start = 1'b1;
    if (!exp_busy && !ila.i_abort) push_seq(ila.i_cfg);
    cycle();
    ila.i_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, 32'(ila.o_data), 32'h0);
    check({tag, "_vld"},  32'(ila.o_vld),  32'h0);
    check({tag, "_k"},    32'(ila.o_k),    32'h0);
    check({tag, "_busy"}, 32'(ila.o_busy), 32'h0);
    check({tag, "_done"}, 32'(ila.o_done), 32'h0);
  endtask

  logic [111:0] cfg_a;

  initial begin
    for (int n = 0; n < 14; n++) cfg_a[8*n +: 8] = 8'hA0 + 8'(n);

    rst_n       = 1'b0;
    ila.i_start = 1'b0;
    ila.i_abort = 1'b0;
    ila.i_cfg   = '0;
    #12;
    check_outputs_zero("reset");
    #1 rst_n = 1'b1;
    run_cycles(3);

    // Full sequence with cfg A0..AD: markers, /Q/, config octets, ramp, done.
    ila.i_cfg = cfg_a;
    pulse_start();
    run_cycles(132);

    // Config changes after capture and a start at octet 40 must not disturb the run.
    pulse_start();
    ila.i_cfg = {14{8'h5A}};
    run_cycles(40);
    pulse_start();
    run_cycles(100);

    // Abort at octet 50.
    ila.i_cfg = cfg_a;
    pulse_start();
    run_cycles(50);
    ila.i_abort = 1'b1;
    if (exp_busy) begin
      sb.delete();
      exp_done = 1'b0;
    end
    cycle();
    ila.i_abort = 1'b0;
    run_cycles(3);

    // Abort together with start while idle: stays idle.
    ila.i_abort = 1'b1;
    pulse_start();
    ila.i_abort = 1'b0;
    run_cycles(3);

    // Fresh start after abort, then a back-to-back restart in the done cycle.
    pulse_start();
    run_cycles(127);
    run_cycles(1);
    check("in_done_cycle", 32'(ila.o_done), 32'h1);
    ila.i_cfg = {14{8'h3C}};
    pulse_start();
    check("restart_R", 32'(ila.o_data), 32'h1C);

    // Asynchronous reset at octet 70.
    run_cycles(70);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    sb.delete();
    exp_done = 1'b0;
    exp_busy = 1'b0;
    #2 rst_n = 1'b1;
    run_cycles(5);

    // One more complete sequence after reset.
    pulse_start();
    run_cycles(130);

    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
